// File: rtl/arb_pkg.sv
// Shared arbiter constants, FSM state type and pointer-advance helper.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index arithmetic is exactly IDX_W bits wide, so 7 wraps to 0.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/onehot_dec3.sv
// 3-to-8 one-hot decode of a grant index, forced to all-zero when not enabled.
// Combinational, zero latency; no flow control.
import arb_pkg::*;

module onehot_dec3 (
    input  logic [IDX_W-1:0]   idx_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with hold timeout; registered one-hot grant and index.
// Latency: request sampled at edge n is granted after edge n; en low blocks new grants only.
import arb_pkg::*;

module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [IDX_W-1:0]    gnt_idx,
    output logic                gnt_valid,
    output logic                timeout
);

    // With the timeout disabled the counter simply saturates at all-ones.
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   cand;

    // First set request scanning upward from the pointer, wrapping 7 -> 0.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && found) begin
                    state_d = GRANT;
                    idx_d   = win;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!req[idx_q]) begin
                    state_d = IDLE;
                    ptr_d   = next_ptr(idx_q);
                end else if ((MAX_HOLD != 0) && (cnt_q == HOLD_LAST)) begin
                    state_d   = IDLE;
                    ptr_d     = next_ptr(idx_q);
                    timeout_d = 1'b1;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = idx_q;
    assign timeout   = timeout_q;

    // Same decoder as the resource side, so the select lines always agree.
    onehot_dec3 u_dec (
        .idx_i    (idx_q),
        .en_i     (gnt_valid),
        .onehot_o (gnt)
    );

endmodule
